// File: rtl/fir_sample_writer_if.sv
// Handshake and FIFO-write bundle between the upstream sample stream, the
// writer block and the FIR input dcfifo (all clk2 domain).
interface fir_sample_writer_if #(
    parameter int DATA_W = 16
) ();
    logic              enable;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              flush_req;
    logic              full;
    logic              write;
    logic [DATA_W-1:0] input_data;
    logic              busy;
    logic              flush_done;
    logic [31:0]       sample_count;
    logic [15:0]       stall_count;

    modport master (
        output enable, s_data, s_valid, flush_req, full,
        input  s_ready, write, input_data, busy, flush_done, sample_count, stall_count
    );

    modport slave (
        input  enable, s_data, s_valid, flush_req, full,
        output s_ready, write, input_data, busy, flush_done, sample_count, stall_count
    );
endinterface

// File: rtl/fir_sample_writer.sv
// Feeds the FIR input dcfifo from a valid/ready stream via a 2-entry skid
// buffer, and on request writes FLUSH_LEN zeros to clear the tap delay line.
module fir_sample_writer #(
    parameter int FLUSH_LEN = 64,
    parameter int DATA_W    = 16
) (
    input logic             clk2,
    input logic             reset,
    fir_sample_writer_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;
    localparam logic [7:0] ZC_LOAD   = 8'(FLUSH_LEN);

    logic [1:0]               r_state;
    logic [1:0]               r_cnt;
    logic                     r_rd_ptr;
    logic                     r_wr_ptr;
    logic signed [DATA_W-1:0] r_mem [2];
    logic [7:0]               r_zc;
    logic                     r_flush_done;
    logic                     r_live;
    logic [31:0]              r_sample_count;
    logic [15:0]              r_stall_count;

    logic w_accept;
    logic w_drain_src;
    logic w_pend;
    logic w_write;
    logic w_pop;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // STREAM only forwards while enabled so the cycle that drops enable never writes.
    assign w_drain_src = ((r_state == ST_STREAM) && bus.enable) || (r_state == ST_DRAIN);
    assign w_pend      = (w_drain_src && (r_cnt != 2'd0)) || (r_state == ST_FLUSH);
    assign w_write     = w_pend && !bus.full;
    assign w_pop       = w_write && (r_state != ST_FLUSH);

    // r_live keeps s_ready low until the first edge after reset release.
    assign bus.s_ready = r_live && (r_cnt != 2'd2) &&
                         ((r_state == ST_IDLE) || (r_state == ST_STREAM));
    assign w_accept    = bus.s_valid && bus.s_ready;

    assign bus.write        = w_write;
    assign bus.input_data   = ((r_cnt != 2'd0) && (r_state != ST_FLUSH)) ? r_mem[r_rd_ptr] : '0;
    assign bus.busy         = (r_state == ST_DRAIN) || (r_state == ST_FLUSH);
    assign bus.flush_done   = r_flush_done;
    assign bus.sample_count = r_sample_count;
    assign bus.stall_count  = r_stall_count;

    always_ff @(posedge clk2) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= bus.s_data;
        end
    end

    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 2'd0;
            r_rd_ptr       <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_zc           <= 8'd0;
            r_flush_done   <= 1'b0;
            r_live         <= 1'b0;
            r_sample_count <= 32'd0;
            r_stall_count  <= 16'd0;
        end else begin
            r_live       <= 1'b1;
            r_flush_done <= 1'b0;
            if (w_accept) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr       <= ~r_rd_ptr;
                r_sample_count <= r_sample_count + 32'd1;
            end
            r_cnt <= r_cnt + 2'(w_accept) - 2'(w_pop);
            if (w_pend && bus.full) begin
                r_stall_count <= sat_inc16(r_stall_count);
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.flush_req) begin
                        r_state <= ST_DRAIN;
                    end else if (bus.enable) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (bus.flush_req) begin
                        r_state <= ST_DRAIN;
                    end else if (!bus.enable) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == 2'd0) begin
                        r_state <= ST_FLUSH;
                        r_zc    <= ZC_LOAD;
                    end
                end
                default: begin
                    // Zero run only advances on an actual write, so full stalls lose nothing.
                    if (w_write) begin
                        r_zc <= r_zc - 8'd1;
                        if (r_zc == 8'd1) begin
                            r_flush_done <= 1'b1;
                            r_state      <= bus.enable ? ST_STREAM : ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_sample_writer.sv
// Scenario bench for fir_sample_writer: a queue holds every sample and flush
// zero the FIFO should receive, and a negedge monitor pops it on each write.
module tb_fir_sample_writer;
    logic clk2;
    logic reset;
    int   n_vec;
    int   n_err;
    int   exp_sc;
    logic [15:0] sb[$];
    logic [15:0] mon_exp;

    fir_sample_writer_if #(.DATA_W(16)) bus ();

    fir_sample_writer #(.FLUSH_LEN(64), .DATA_W(16)) dut (
        .clk2  (clk2),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    initial begin
        #300000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk2) begin
        if (!reset && bus.write) begin
            n_vec++;
            if (bus.full) begin
                n_err++;
                $display("FAIL write_under_full write=%b full=%b required no write", bus.write, bus.full);
            end
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write data=%h required no write", bus.input_data);
            end else begin
                mon_exp = sb.pop_front();
                if (bus.input_data !== mon_exp) begin
                    n_err++;
                    $display("FAIL write_data got=%h required=%h", bus.input_data, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk2);
            if (bus.s_ready) begin
                sb.push_back(d);
                exp_sc++;
                tick();
                bus.s_valid = 1'b0;
                return;
            end
            tick();
        end
        n_vec++;
        n_err++;
        $display("FAIL send_timeout data=%h s_ready=%b required 1", d, bus.s_ready);
        bus.s_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk2);
        @(negedge clk2);
        n_vec++;
        if ({bus.s_ready, bus.write, bus.busy, bus.flush_done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags rdy/wr/busy/done=%b required 0000",
                     {bus.s_ready, bus.write, bus.busy, bus.flush_done});
        end
        n_vec++;
        if (bus.input_data !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_input_data got=%h required 0000", bus.input_data);
        end
        n_vec++;
        if (bus.sample_count !== 32'd0 || bus.stall_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_counters got=%0d/%0d required 0/0", bus.sample_count, bus.stall_count);
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if (bus.s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready got=%b required 1", bus.s_ready);
        end
        exp_sc = 0;
    endtask

    task automatic test_stream();
        int nw = 0;
        int first = -1;
        int last = -1;
        bit drop = 1'b0;
        bus.enable = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            bus.s_valid = (i < 16);
            bus.s_data  = 16'(i + 1);
            @(negedge clk2);
            if (i < 16) begin
                if (!bus.s_ready) drop = 1'b1;
                else begin
                    sb.push_back(16'(i + 1));
                    exp_sc++;
                end
            end
            if (bus.write) begin
                nw++;
                if (first < 0) first = i;
                last = i;
            end
            tick();
        end
        bus.s_valid = 1'b0;
        n_vec++;
        if (drop !== 1'b0) begin
            n_err++;
            $display("FAIL stream_ready_drop got=%b required 0", drop);
        end
        n_vec++;
        if (nw !== 16 || (last - first) !== 15) begin
            n_err++;
            $display("FAIL stream_burst writes=%0d span=%0d required 16/15", nw, last - first);
        end
        n_vec++;
        if (first !== 1) begin
            n_err++;
            $display("FAIL stream_latency first_write_cycle=%0d required 1", first);
        end
        n_vec++;
        if (bus.sample_count !== 32'd16) begin
            n_err++;
            $display("FAIL stream_sample_count got=%0d required 16", bus.sample_count);
        end
    endtask

    task automatic test_full_stall();
        int k = 0;
        bit drop = 1'b0;
        for (int i = 0; i < 25; i++) begin
            bus.full    = (i >= 5 && i < 10);
            bus.s_valid = (i < 20);
            bus.s_data  = 16'h0100 + 16'(k);
            @(negedge clk2);
            if (bus.full) begin
                n_vec++;
                if (bus.write !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_write cycle=%0d got=%b required 0", i, bus.write);
                end
            end
            if (i < 20) begin
                if (!bus.s_ready) drop = 1'b1;
                else begin
                    sb.push_back(16'h0100 + 16'(k));
                    exp_sc++;
                    k++;
                end
            end
            tick();
        end
        bus.full    = 1'b0;
        bus.s_valid = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (bus.stall_count !== 16'd5) begin
            n_err++;
            $display("FAIL stall_count got=%0d required 5", bus.stall_count);
        end
        n_vec++;
        if (drop !== 1'b1) begin
            n_err++;
            $display("FAIL stall_ready_drop got=%b required 1", drop);
        end
        n_vec++;
        if (sb.size() !== 0 || bus.sample_count !== 32'(exp_sc)) begin
            n_err++;
            $display("FAIL stall_drain pending=%0d count=%0d required 0/%0d", sb.size(), bus.sample_count, exp_sc);
        end
    endtask

    task automatic test_enable_hold();
        bus.enable = 1'b0;
        tick();
        tick();
        send(16'hAAAA);
        send(16'h5555);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk2);
            n_vec++;
            if (bus.s_ready !== 1'b0 || bus.write !== 1'b0) begin
                n_err++;
                $display("FAIL hold_idle s_ready/write=%b%b required 00", bus.s_ready, bus.write);
            end
            tick();
        end
        bus.enable = 1'b1;
        tick();
        @(negedge clk2);
        n_vec++;
        if (bus.write !== 1'b1 || bus.input_data !== 16'hAAAA) begin
            n_err++;
            $display("FAIL hold_first write=%b data=%h required 1/aaaa", bus.write, bus.input_data);
        end
        tick();
        @(negedge clk2);
        n_vec++;
        if (bus.write !== 1'b1 || bus.input_data !== 16'h5555) begin
            n_err++;
            $display("FAIL hold_second write=%b data=%h required 1/5555", bus.write, bus.input_data);
        end
        tick();
        tick();
    endtask

    task automatic test_flush(input bit toggle);
        int zeros = 0;
        int done_n = 0;
        int after_done = -1;
        bit prev = 1'b0;
        bit busy_seen = 1'b0;
        bus.enable = 1'b0;
        tick();
        tick();
        send(16'h1234);
        send(16'h4321);
        bus.flush_req = 1'b1;
        @(negedge clk2);
        for (int z = 0; z < 64; z++) sb.push_back(16'h0000);
        tick();
        bus.flush_req = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bus.full      = toggle ? i[0] : 1'b0;
            bus.flush_req = (i == 30);
            @(negedge clk2);
            if (bus.busy) busy_seen = 1'b1;
            if (bus.write && bus.input_data == 16'h0000) zeros++;
            if (bus.flush_done) begin
                done_n++;
                after_done = i;
                n_vec++;
                if (zeros !== 64 || prev !== 1'b1) begin
                    n_err++;
                    $display("FAIL flush_done_timing zeros=%0d prev_write=%b required 64/1", zeros, prev);
                end
            end
            prev = bus.write;
            tick();
            if (after_done >= 0 && i >= after_done + 4) break;
        end
        bus.full      = 1'b0;
        bus.flush_req = 1'b0;
        n_vec++;
        if (done_n !== 1 || zeros !== 64) begin
            n_err++;
            $display("FAIL flush_run toggle=%0d done_pulses=%0d zeros=%0d required 1/64", toggle, done_n, zeros);
        end
        n_vec++;
        if (busy_seen !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_busy seen=%b now=%b required 1/0", busy_seen, bus.busy);
        end
        n_vec++;
        if (bus.sample_count !== 32'(exp_sc) || sb.size() !== 0) begin
            n_err++;
            $display("FAIL flush_count count=%0d pending=%0d required %0d/0", bus.sample_count, sb.size(), exp_sc);
        end
    endtask

    task automatic test_reset_mid_flush();
        int zeros = 0;
        int ws = 0;
        bit fd = 1'b0;
        bus.enable    = 1'b0;
        tick();
        bus.flush_req = 1'b1;
        @(negedge clk2);
        for (int z = 0; z < 64; z++) sb.push_back(16'h0000);
        tick();
        bus.flush_req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk2);
            if (bus.write) zeros++;
            if (zeros == 10) break;
            tick();
        end
        tick();
        reset = 1'b1;
        #1;
        n_vec++;
        if (zeros !== 10) begin
            n_err++;
            $display("FAIL rstflush_progress zeros=%0d required 10", zeros);
        end
        n_vec++;
        if ({bus.s_ready, bus.write, bus.busy, bus.flush_done} !== 4'b0000 || bus.input_data !== 16'h0000) begin
            n_err++;
            $display("FAIL rstflush_async rdy/wr/busy/done=%b data=%h required 0000/0000",
                     {bus.s_ready, bus.write, bus.busy, bus.flush_done}, bus.input_data);
        end
        n_vec++;
        if (bus.sample_count !== 32'd0 || bus.stall_count !== 16'd0) begin
            n_err++;
            $display("FAIL rstflush_counters got=%0d/%0d required 0/0", bus.sample_count, bus.stall_count);
        end
        sb.delete();
        exp_sc = 0;
        @(negedge clk2);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            @(negedge clk2);
            if (bus.write) ws++;
            if (bus.flush_done) fd = 1'b1;
        end
        n_vec++;
        if (ws !== 0 || fd !== 1'b0) begin
            n_err++;
            $display("FAIL rstflush_after writes=%0d done=%b required 0/0", ws, fd);
        end
        n_vec++;
        if (bus.busy !== 1'b0 || bus.s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstflush_idle busy=%b s_ready=%b required 0/1", bus.busy, bus.s_ready);
        end
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        exp_sc        = 0;
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.s_data    = 16'h0000;
        bus.s_valid   = 1'b0;
        bus.flush_req = 1'b0;
        bus.full      = 1'b0;
        test_reset();
        test_stream();
        test_full_stall();
        test_enable_hold();
        test_flush(1'b0);
        test_flush(1'b1);
        test_reset_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
